// File: rtl/cdc_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_rx
// Description : Destination side of a 4-phase req/ack CDC handshake with
//               request synchronizer, consumer valid/ready and a timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_STAGES  = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  REQ_ASYNC,
  input  logic [DATA_WIDTH-1:0] DATA_ASYNC,
  input  logic                  OUT_READY,
  input  logic                  ERR_CLR,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  output logic                  ACK,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VALID  = 2'd1,
    ACK_HI = 2'd2
  } state_t;

  logic [NUM_STAGES-1:0] r_sync;
  logic                  w_req_s;
  state_t                r_state,    w_state_nx;
  logic [DATA_WIDTH-1:0] r_out_data, w_out_data_nx;
  logic                  r_valid,    w_valid_nx;
  logic                  r_ack,      w_ack_nx;
  logic                  r_err,      w_err_nx;
  logic [c_CNT_W-1:0]    r_cnt,      w_cnt_nx;

  // Request synchronizer; only its last stage is visible to the FSM.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_sync <= '0;
    else        r_sync <= {r_sync[NUM_STAGES-2:0], REQ_ASYNC};
  end

  assign w_req_s = r_sync[NUM_STAGES-1];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= IDLE;
      r_out_data <= '0;
      r_valid    <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_out_data <= w_out_data_nx;
      r_valid    <= w_valid_nx;
      r_ack      <= w_ack_nx;
      r_err      <= w_err_nx;
      r_cnt      <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_out_data_nx = r_out_data;
    w_valid_nx    = r_valid;
    w_ack_nx      = r_ack;
    w_cnt_nx      = r_cnt;
    w_err_nx      = r_err;

    case (r_state)
      IDLE: begin
        if (w_req_s) begin
          w_out_data_nx = DATA_ASYNC;
          w_valid_nx    = 1'b1;
          w_state_nx    = VALID;
        end
      end
      VALID: begin
        if (OUT_READY) begin
          w_valid_nx = 1'b0;
          w_ack_nx   = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!w_req_s) begin
          w_ack_nx   = 1'b0;
          w_state_nx = IDLE;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt_nx = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase

    // Set has priority over clear; the stale counter is ignored outside ACK_HI.
    if ((r_state == ACK_HI) && (r_cnt == c_CNT_MAX)) w_err_nx = 1'b1;
    else if (ERR_CLR)                                w_err_nx = 1'b0;
  end

  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_valid;
  assign ACK       = r_ack;
  assign ERR       = r_err;
  assign BUSY      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_handshake_rx
// Description : Self-checking bench: directed scenarios plus randomized
//               4-phase traffic against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_rx;

  localparam int DW  = 8;
  localparam int NS  = 2;
  localparam int TO  = 4;
  localparam int LAT = NS + 1;
  localparam int N_RAND = 20;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          REQ_ASYNC = 1'b0;
  logic [DW-1:0] DATA_ASYNC = '0;
  logic          OUT_READY = 1'b0;
  logic          ERR_CLR = 1'b0;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID, ACK, BUSY, ERR;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int n_hs = 0;
  bit mon_en = 1'b0;
  bit src_done = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ack = 1'b0;
  logic [DW-1:0] exp_data[$];
  int            exp_edge[$];

  cdc_handshake_rx #(
    .DATA_WIDTH (DW),
    .NUM_STAGES (NS),
    .TIMEOUT_CYC(TO)
  ) u_dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .REQ_ASYNC (REQ_ASYNC),
    .DATA_ASYNC(DATA_ASYNC),
    .OUT_READY (OUT_READY),
    .ERR_CLR   (ERR_CLR),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .ACK       (ACK),
    .BUSY      (BUSY),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int k = 0;
    while (ACK !== lvl && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, 32'(ACK), 32'(lvl));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(OUT_VALID), 0);
    chk({tag, "_ack"},   32'(ACK),       0);
    chk({tag, "_busy"},  32'(BUSY),      0);
    chk({tag, "_data"},  32'(OUT_DATA),  0);
    chk({tag, "_err"},   32'(ERR),       0);
  endtask

  // Transaction-level reference: each request yields one valid after LAT edges
  // and one acknowledge, in order, carrying exactly the sent value.
  always @(posedge CLK) begin
    #1;
    if (mon_en) begin
      if (OUT_VALID && !prev_valid) begin
        if (exp_data.size() == 0) chk("mon_extra_valid", exp_data.size(), 1);
        else begin
          chk("mon_latency", edge_cnt, exp_edge[0]);
          chk("mon_valid_data", 32'(OUT_DATA), 32'(exp_data[0]));
        end
      end
      if (ACK && !prev_ack) begin
        n_hs++;
        if (exp_data.size() == 0) chk("mon_extra_ack", exp_data.size(), 1);
        else begin
          chk("mon_ack_data", 32'(OUT_DATA), 32'(exp_data.pop_front()));
          void'(exp_edge.pop_front());
        end
      end
    end
    prev_valid = OUT_VALID;
    prev_ack   = ACK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] vals[4];
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h3C; vals[3] = 8'hC3;

    tick(2);
    chk_all_zero("reset");
    RST_n = 1'b1;
    tick(2);

    // Basic transfer
    DATA_ASYNC = 8'hA5; REQ_ASYNC = 1'b1; OUT_READY = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      chk("basic_latency", 32'(OUT_VALID), 32'(i == LAT));
    end
    chk("basic_data", 32'(OUT_DATA), 32'hA5);
    chk("basic_busy", 32'(BUSY), 1);
    tick(1);
    chk("basic_ack", 32'(ACK), 1);
    chk("basic_valid_low", 32'(OUT_VALID), 0);
    REQ_ASYNC = 1'b0; OUT_READY = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      chk("basic_ack_fall", 32'(ACK), 32'(i != LAT));
    end
    chk("basic_idle_busy", 32'(BUSY), 0);
    chk("basic_data_hold", 32'(OUT_DATA), 32'hA5);

    // Backpressure
    d = 8'($urandom);
    DATA_ASYNC = d; REQ_ASYNC = 1'b1;
    tick(LAT);
    chk("bp_valid", 32'(OUT_VALID), 1);
    DATA_ASYNC = ~d;
    repeat (10) begin
      tick(1);
      chk("bp_valid_hold", 32'(OUT_VALID), 1);
      chk("bp_data_hold", 32'(OUT_DATA), 32'(d));
      chk("bp_ack_low", 32'(ACK), 0);
    end
    OUT_READY = 1'b1;
    tick(1);
    chk("bp_ack", 32'(ACK), 1);
    chk("bp_valid_low", 32'(OUT_VALID), 0);
    OUT_READY = 1'b0; REQ_ASYNC = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");

    // Timeout with request stuck high
    DATA_ASYNC = 8'($urandom); REQ_ASYNC = 1'b1; OUT_READY = 1'b1;
    tick(LAT + 1);
    chk("to_ack", 32'(ACK), 1);
    OUT_READY = 1'b0;
    for (int i = 1; i <= TO + 1; i++) begin
      tick(1);
      chk("to_err", 32'(ERR), 32'(i == TO + 1));
      chk("to_ack_hold", 32'(ACK), 1);
    end
    ERR_CLR = 1'b1;
    repeat (3) begin
      tick(1);
      chk("to_clr_vs_set", 32'(ERR), 1);
    end
    ERR_CLR = 1'b0; REQ_ASYNC = 1'b0;
    wait_ack(1'b0, "to_ack_fall");
    tick(1);
    chk("to_sticky", 32'(ERR), 1);
    ERR_CLR = 1'b1;
    tick(1);
    chk("to_clear", 32'(ERR), 0);
    ERR_CLR = 1'b0;
    tick(1);
    chk("to_clear_hold", 32'(ERR), 0);

    // Back-to-back fixed values followed by randomized traffic
    mon_en = 1'b1;
    fork
      begin
        for (int t = 0; t < 4 + N_RAND; t++) begin
          d = (t < 4) ? vals[t] : 8'($urandom);
          DATA_ASYNC = d;
          exp_data.push_back(d);
          exp_edge.push_back(edge_cnt + LAT);
          REQ_ASYNC = 1'b1;
          wait_ack(1'b1, "src_ack_rise");
          REQ_ASYNC = 1'b0;
          wait_ack(1'b0, "src_ack_fall");
          tick($urandom_range(0, 3));
        end
        src_done = 1'b1;
      end
      begin
        while (!src_done) begin
          @(negedge CLK);
          OUT_READY = 1'($urandom_range(0, 1));
        end
      end
    join
    OUT_READY = 1'b0;
    tick(2);
    mon_en = 1'b0;
    chk("hs_count", n_hs, 4 + N_RAND);
    chk("hs_leftover", exp_data.size(), 0);
    chk("traffic_no_err", 32'(ERR), 0);

    // Reset while in VALID
    DATA_ASYNC = 8'h5A; REQ_ASYNC = 1'b1;
    tick(LAT);
    chk("rv_valid", 32'(OUT_VALID), 1);
    #2 RST_n = 1'b0;
    #1 chk_all_zero("rv_async");
    @(negedge CLK);
    DATA_ASYNC = 8'h96;
    RST_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      chk("rv_relatency", 32'(OUT_VALID), 32'(i == LAT));
    end
    chk("rv_redata", 32'(OUT_DATA), 32'h96);

    // Reset while in ACK_HI
    OUT_READY = 1'b1;
    tick(1);
    chk("ra_ack", 32'(ACK), 1);
    OUT_READY = 1'b0;
    #2 RST_n = 1'b0;
    #1 chk_all_zero("ra_async");
    @(negedge CLK);
    DATA_ASYNC = 8'hC3;
    RST_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      chk("ra_relatency", 32'(OUT_VALID), 32'(i == LAT));
      chk("ra_no_ack", 32'(ACK), 0);
    end
    chk("ra_redata", 32'(OUT_DATA), 32'hC3);
    OUT_READY = 1'b1;
    wait_ack(1'b1, "end_ack_rise");
    REQ_ASYNC = 1'b0; OUT_READY = 1'b0;
    wait_ack(1'b0, "end_ack_fall");
    chk("end_busy", 32'(BUSY), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
